// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry, the
// per-cycle operation encoding and the pointer/count width helper.
package fifo_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_DEPTH  = 16;

    // Operation accepted in a cycle, encoded as {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Ceiling log2. Used for pointer width (clog2(DEPTH)) and count width
    // (clog2(DEPTH)+1, which also holds the value DEPTH itself).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: one synchronous write port and one
// registered read port with read-enable. Only the read register is reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rdata;

    // Write port: store the word on an enabled write.
    // NOTE: the storage array is deliberately not reset; reset empties the
    // FIFO through its pointers, and a reset here would prevent RAM inference.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: capture the addressed word on a read, otherwise hold.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync.sv
// Parametrised single-clock FIFO with registered read data and valid strobe,
// occupancy count, almost-full/almost-empty thresholds and registered
// overflow/underflow pulses. Holds pointers, count and flag decode; storage
// lives in fifo_mem.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DWIDTH-1:0] i_din,
    input  logic              i_rd,
    output logic [DWIDTH-1:0] o_dout,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    fifo_op_e      w_op;

    // Flags decode the registered count only, so a same-cycle read never
    // relaxes full and a same-cycle write never relaxes empty.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = i_wr && !w_full;
    assign w_rd_acc = i_rd && !w_empty;
    assign w_op     = fifo_op_e'({w_wr_acc, w_rd_acc});

    // Pointers wrap naturally at DEPTH; count moves only when exactly one
    // side is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case (w_op)
                OP_WR:   r_count <= r_count + CW'(1);
                OP_RD:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read strobe and error pulses: one cycle per accepted read or rejected
    // request, repeating while the illegal request is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid     <= w_rd_acc;
            r_overflow  <= i_wr && w_full;
            r_underflow <= i_rd && w_empty;
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_wr_acc && !i_rst),
        .i_waddr (r_wptr),
        .i_wdata (i_din),
        .i_re    (w_rd_acc && !i_rst),
        .i_raddr (r_rptr),
        .o_rdata (o_dout)
    );

    assign o_valid        = r_valid;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= CW'(AF_LEVEL));
    assign o_almost_empty = (r_count <= CW'(AE_LEVEL));
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a default 8x16 instance and a 32x4 instance
// with AF_LEVEL=3, AE_LEVEL=1, sharing one clock.
module tb_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       a_rst, a_wr, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_valid, a_full, a_empty, a_almost_full, a_almost_empty;
    logic [4:0] a_count;
    logic       a_overflow, a_underflow;

    // Small wide instance
    logic        b_rst, b_wr, b_rd;
    logic [31:0] b_din, b_dout;
    logic        b_valid, b_full, b_empty, b_almost_full, b_almost_empty;
    logic [2:0]  b_count;
    logic        b_overflow, b_underflow;

    int tests = 0;
    int fails = 0;

    fifo_sync u_a (
        .i_clk          (clk),
        .i_rst          (a_rst),
        .i_wr           (a_wr),
        .i_din          (a_din),
        .i_rd           (a_rd),
        .o_dout         (a_dout),
        .o_valid        (a_valid),
        .o_full         (a_full),
        .o_empty        (a_empty),
        .o_almost_full  (a_almost_full),
        .o_almost_empty (a_almost_empty),
        .o_count        (a_count),
        .o_overflow     (a_overflow),
        .o_underflow    (a_underflow)
    );

    fifo_sync #(
        .DWIDTH   (32),
        .DEPTH    (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) u_b (
        .i_clk          (clk),
        .i_rst          (b_rst),
        .i_wr           (b_wr),
        .i_din          (b_din),
        .i_rd           (b_rd),
        .o_dout         (b_dout),
        .o_valid        (b_valid),
        .o_full         (b_full),
        .o_empty        (b_empty),
        .o_almost_full  (b_almost_full),
        .o_almost_empty (b_almost_empty),
        .o_count        (b_count),
        .o_overflow     (b_overflow),
        .o_underflow    (b_underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  init_w [5];
        logic [31:0] bw [4];
        logic [7:0]  exp_b;
        init_w = '{8'h3C, 8'h40, 8'h41, 8'h42, 8'h43};
        bw     = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};

        a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
        b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        step();

        // Reset / idle defaults
        check("rst_count", a_count, 0);
        check("rst_empty", a_empty, 1);
        check("rst_ae", a_almost_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_af", a_almost_full, 0);
        check("rst_valid", a_valid, 0);
        check("rst_dout", a_dout, 0);
        check("rst_ovf", a_overflow, 0);
        check("rst_unf", a_underflow, 0);
        check("b_rst_count", b_count, 0);
        check("b_rst_empty", b_empty, 1);
        check("b_rst_full", b_full, 0);
        check("b_rst_unf", b_underflow, 0);

        // Fill 0x00..0x0F: almost_full from count 14, full at 16
        for (int i = 0; i < 16; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(i);
            step();
            check("fill_count", a_count, 64'(i + 1));
            check("fill_af", a_almost_full, 64'(i + 1 >= 14));
            check("fill_full", a_full, 64'(i + 1 == 16));
            check("fill_empty", a_empty, 0);
        end

        // 17th write rejected
        a_din = 8'h99;
        step();
        check("ovf_pulse", a_overflow, 1);
        check("ovf_count", a_count, 16);
        a_wr = 1'b0;
        step();
        check("ovf_clear", a_overflow, 0);
        check("ovf_count_hold", a_count, 16);

        // Drain: 0x00..0x0F in order, valid held high
        a_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_valid", a_valid, 1);
            check("drain_dout", a_dout, 64'(i));
            check("drain_count", a_count, 64'(15 - i));
            check("drain_ae", a_almost_empty, 64'(15 - i <= 2));
        end

        // 17th read rejected
        step();
        check("unf_pulse", a_underflow, 1);
        check("unf_valid", a_valid, 0);
        check("unf_dout_hold", a_dout, 8'h0F);
        check("unf_empty", a_empty, 1);
        a_rd = 1'b0;
        step();
        check("unf_clear", a_underflow, 0);

        // wr && rd while empty: only the write is taken
        a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h3C;
        step();
        check("empty_rw_count", a_count, 1);
        check("empty_rw_unf", a_underflow, 1);
        check("empty_rw_valid", a_valid, 0);
        check("empty_rw_empty", a_empty, 0);
        a_rd = 1'b0;
        for (int j = 0; j < 4; j++) begin
            a_din = 8'(8'h40 + j);
            step();
        end
        check("pre_rw_count", a_count, 5);

        // Streaming at count 5 for 40 cycles: output lags input by 5 words
        a_rd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a_din = 8'(8'h80 + k);
            step();
            exp_b = (k < 5) ? init_w[k] : 8'(8'h80 + k - 5);
            check("stream_dout", a_dout, exp_b);
            check("stream_valid", a_valid, 1);
            check("stream_count", a_count, 5);
        end
        a_wr = 1'b0; a_rd = 1'b0;
        step();
        check("stream_valid_drop", a_valid, 0);
        check("stream_dout_hold", a_dout, 8'hA2);
        check("stream_count_end", a_count, 5);

        // Refill to full, then wr && rd while full
        a_wr = 1'b1;
        for (int j = 0; j < 11; j++) begin
            a_din = 8'(8'hC0 + j);
            step();
        end
        check("refill_full", a_full, 1);
        a_rd = 1'b1; a_din = 8'hEE;
        step();
        check("full_rw_ovf", a_overflow, 1);
        check("full_rw_valid", a_valid, 1);
        check("full_rw_dout", a_dout, 8'hA3);
        check("full_rw_count", a_count, 15);
        check("full_rw_full", a_full, 0);

        // Read down to 9: A4..A7, C0, C1
        a_wr = 1'b0;
        for (int j = 0; j < 6; j++) step();
        check("to9_count", a_count, 9);
        check("to9_dout", a_dout, 8'hC1);

        // Reset mid-operation with wr=rd=1
        a_wr = 1'b1; a_rd = 1'b1; a_rst = 1'b1;
        step();
        check("mid_rst_count", a_count, 0);
        check("mid_rst_empty", a_empty, 1);
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_dout", a_dout, 0);
        a_rst = 1'b0; a_rd = 1'b0; a_din = 8'hA5;
        step();
        check("post_rst_count", a_count, 1);
        a_wr = 1'b0; a_rd = 1'b1;
        step();
        check("post_rst_dout", a_dout, 8'hA5);
        check("post_rst_valid", a_valid, 1);
        a_rd = 1'b0;
        step();
        check("post_rst_valid_drop", a_valid, 0);

        // Wide/shallow instance: thresholds AF=3, AE=1
        b_wr = 1'b1;
        for (int j = 0; j < 4; j++) begin
            b_din = bw[j];
            step();
            check("b_fill_count", b_count, 64'(j + 1));
            check("b_fill_af", b_almost_full, 64'(j + 1 >= 3));
            check("b_fill_ae", b_almost_empty, 64'(j + 1 <= 1));
            check("b_fill_full", b_full, 64'(j + 1 == 4));
        end
        b_din = '0;
        step();
        check("b_ovf", b_overflow, 1);
        check("b_ovf_count", b_count, 4);
        b_wr = 1'b0; b_rd = 1'b1;
        step();
        check("b_rd0", b_dout, 32'hDEADBEEF);
        check("b_rd0_valid", b_valid, 1);
        check("b_rd0_af", b_almost_full, 1);
        step();
        check("b_rd1", b_dout, 32'h01234567);
        check("b_rd1_af", b_almost_full, 0);
        check("b_rd1_ae", b_almost_empty, 0);
        b_wr = 1'b1; b_rst = 1'b1;
        step();
        check("b_mid_rst_count", b_count, 0);
        check("b_mid_rst_empty", b_empty, 1);
        check("b_mid_rst_ae", b_almost_empty, 1);
        b_rst = 1'b0; b_rd = 1'b0; b_din = 32'h000000A5;
        step();
        check("b_post_rst_count", b_count, 1);
        b_wr = 1'b0; b_rd = 1'b1;
        step();
        check("b_post_rst_dout", b_dout, 32'h000000A5);
        check("b_post_rst_valid", b_valid, 1);
        b_rd = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised synchronous FIFO, the successor to the fixed 8-bit × 16 FIFO. It adds configurable data width and depth, concurrent read and write in one cycle, and a registered read port with a valid strobe. It also provides programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. It sits between a single-clock producer and consumer anywhere in the datapath.

## Interface
- DWIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr  input  1  write request
- din  input  DWIDTH  write data
- rd  input  1  read request
- dout  output  DWIDTH  read data, registered
- valid  output  1  dout carries a newly read word this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: a write was rejected because the FIFO was full
- underflow  output  1  one-cycle pulse: a read was rejected because the FIFO was empty

## Operation
- Write is accepted iff wr && !full, sampled on pre-edge state.
  - An accepted write stores din at wptr and increments wptr.
- Read is accepted iff rd && !empty, sampled on pre-edge state.
  - An accepted read loads mem[rptr] into dout, increments rptr, and sets valid=1 for one cycle.
- Both accepted in the same cycle: both pointers advance and count is unchanged. Data ordering is strictly FIFO.
- Full with wr && rd: only the read is accepted and the write is rejected (overflow pulses). Full is never relaxed by a same-cycle read.
- Empty with wr && rd: only the write is accepted (underflow pulses). There is no write-to-read bypass.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special handling.
- Status flags (full, empty, almost_full, almost_empty) are combinational decodes of the registered count.
- dout holds its last value when no read is accepted. It is always driven, never high-Z.
- overflow/underflow are registered and assert the cycle after the offending request. They do not alter pointers, count or memory.
- rst takes priority over wr and rd. Reset mid-operation discards all contents; memory array is not cleared.
- Reset values:
  - wptr, rptr and count reset to 0.
  - dout resets to 0.
  - valid, overflow and underflow reset to 0.
  - empty resets to 1 and full to 0.
  - almost_empty resets to 1; almost_full resets to 0.

## Timing
- Write-to-visible: a word written at edge N is readable by a rd sampled at edge N+1, so empty deasserts after edge N.
- Read latency: rd accepted at edge N gives dout/valid valid after edge N, for one cycle.
- Back-to-back reads at full rate produce one word per cycle with valid held high.
- count and all flags update on the same edge as the accepted operation.
- Error pulses are one cycle wide. They repeat every cycle the illegal request is held.

## Structure
- Shared package fifo_pkg:
  - default DWIDTH/DEPTH constants
  - count/pointer width helper (clog2)
- Sub-module fifo_mem:
  - simple dual-port array, DEPTH × DWIDTH
  - one synchronous write port and one registered read port with read-enable
  - no reset on storage
- Top level holds pointers, count, flag decode and error pulses.

## Test plan
- Reset then idle, defaults:
  - count=0, empty=1, almost_empty=1, full=0, valid=0, dout=0.
- Fill and drain, defaults:
  - Write 16 words 0x00..0x0F: count reaches 16, almost_full asserts at count=14, full at 16.
  - Then a 17th write: overflow pulses once, count stays 16.
- Drain after fill:
  - 16 reads return 0x00..0x0F in order, each with valid=1 one cycle after rd.
  - A 17th read: underflow pulses, valid=0, dout holds 0x0F.
- Simultaneous rd and wr at count=5, held for 40 cycles:
  - count stays 5 throughout and pointers wrap twice.
  - Output sequence matches the input sequence delayed by 5 words.
- Boundary cases:
  - wr && rd while full: only the read is accepted and overflow pulses.
  - wr && rd while empty: only the write is accepted, count=1, underflow pulses, valid=0.
- Reset mid-operation and non-default parameters:
  - Assert rst at count=9 with wr=rd=1: next cycle count=0 and empty=1.
  - A subsequent write/read of 0xA5 returns 0xA5.
  - Repeat with DWIDTH=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1: flags track the thresholds.
